reset_release_sequencer: RTL and testbench

//  Consumer side of the reset generator: accepts the board-level async reset, synchronises its release,

---
 rtl/reset_release_sequencer.sv | 193 +++++++++++++++++++
 tb/tb_reset_release_sequencer.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/reset_release_sequencer.sv
// reset_release_sequencer
//   Takes the board-level asynchronous reset and synchronises its release.
//   It then holds every downstream domain in reset for HOLD_CYCLES and
//   releases the NUM_STAGES domains one at a time, in order 0..NUM_STAGES-1.
//   Each stage must acknowledge on stage_ready before the next stage is
//   released. A stage that does not answer within TIMEOUT_CYCLES puts every
//   domain back into reset and raises a sticky error.
//
// Ports
//   clk          system clock
//   reset_n      asynchronous assert, active-low; release synchronised here
//   soft_reset   synchronous active-high request to rerun the whole sequence
//   stage_ready  per-domain init-done, synchronous to clk
//   stage_reset  per-domain reset, active-high, registered
//   all_ready    every stage released and acknowledged
//   busy         sequence in progress (hold or waiting on a stage)
//   timeout_err  sticky stage-timeout / ready-loss flag
//   err_stage    index of the failing stage
//
// Build option
//   RST_SEQ_READY_MON_EN : once all stages are up, any stage_ready going low
//                          triggers the error state. Without it, the all-ready
//                          state is kept until soft_reset or reset_n.
module reset_release_sequencer #(
  parameter int unsigned NUM_STAGES     = 4,
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned HOLD_CYCLES    = 100,
  parameter int unsigned TIMEOUT_CYCLES = 65535,
  localparam int unsigned SW = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  soft_reset,
  input  logic [NUM_STAGES-1:0] stage_ready,
  output logic [NUM_STAGES-1:0] stage_reset,
  output logic                  all_ready,
  output logic                  busy,
  output logic                  timeout_err,
  output logic [SW-1:0]         err_stage
);

  localparam int unsigned CMAX = (HOLD_CYCLES > TIMEOUT_CYCLES) ? HOLD_CYCLES : TIMEOUT_CYCLES;
  localparam int unsigned CW   = $clog2(CMAX + 1);
  localparam int unsigned TO_M1 = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;

  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST   = CW'(TO_M1);
  localparam logic [CW-1:0] CNT_MAX   = '1;
  localparam logic [SW-1:0] LAST_IDX  = SW'(NUM_STAGES - 1);

  typedef enum logic [1:0] {
    S_HOLD,
    S_WAIT,
    S_DONE,
    S_ERROR
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   run;

  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d, cnt_inc;
  logic [SW-1:0]          idx_q, idx_d;
  logic                   ign_q, ign_d;
  logic [NUM_STAGES-1:0]  stage_reset_d;
  logic                   all_ready_d, busy_d, timeout_err_d;
  logic [SW-1:0]          err_stage_d;
  logic                   ready_now;

  // Release synchroniser: run goes high SYNC_STAGES edges after reset_n rises.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign run = sync_q[SYNC_STAGES-1];

`ifdef RST_SEQ_READY_MON_EN
  logic [SW-1:0] low_idx;

  // Scan downwards so the lowest dropped index is the one that remains.
  always_comb begin
    low_idx = '0;
    for (int unsigned i = NUM_STAGES; i > 0; i--) begin
      if (!stage_ready[i-1]) begin
        low_idx = SW'(i - 1);
      end
    end
  end
`endif

  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);

  // A freshly released domain still reports its pre-release ready during
  // its first cycle out of reset, so that one sample is masked.
  assign ready_now = stage_ready[idx_q] && !ign_q;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    idx_d         = idx_q;
    ign_d         = 1'b0;
    stage_reset_d = stage_reset;
    timeout_err_d = timeout_err;
    err_stage_d   = err_stage;

    if (!run || soft_reset) begin
      state_d       = S_HOLD;
      cnt_d         = '0;
      idx_d         = '0;
      stage_reset_d = '1;
      timeout_err_d = 1'b0;
      err_stage_d   = '0;
    end else begin
      case (state_q)
        S_HOLD: begin
          if (cnt_q == HOLD_LAST) begin
            stage_reset_d[0] = 1'b0;
            idx_d            = '0;
            cnt_d            = '0;
            ign_d            = 1'b1;
            state_d          = S_WAIT;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        S_WAIT: begin
          cnt_d = cnt_inc;
          // Ready is checked before the timeout, so it wins on the same edge.
          if (ready_now) begin
            if (idx_q == LAST_IDX) begin
              state_d = S_DONE;
            end else begin
              stage_reset_d[idx_q + SW'(1)] = 1'b0;
              idx_d = idx_q + SW'(1);
              cnt_d = '0;
              ign_d = 1'b1;
            end
          end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == TO_LAST)) begin
            state_d       = S_ERROR;
            stage_reset_d = '1;
            timeout_err_d = 1'b1;
            err_stage_d   = idx_q;
          end
        end
        S_DONE: begin
`ifdef RST_SEQ_READY_MON_EN
          if (!(&stage_ready)) begin
            state_d       = S_ERROR;
            stage_reset_d = '1;
            timeout_err_d = 1'b1;
            err_stage_d   = low_idx;
          end
`endif
        end
        default: begin
          state_d = S_ERROR;
        end
      endcase
    end

    all_ready_d = (state_d == S_DONE);
    busy_d      = (state_d == S_HOLD) || (state_d == S_WAIT);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_HOLD;
      cnt_q       <= '0;
      idx_q       <= '0;
      ign_q       <= 1'b0;
      stage_reset <= '1;
      all_ready   <= 1'b0;
      busy        <= 1'b1;
      timeout_err <= 1'b0;
      err_stage   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      ign_q       <= ign_d;
      stage_reset <= stage_reset_d;
      all_ready   <= all_ready_d;
      busy        <= busy_d;
      timeout_err <= timeout_err_d;
      err_stage   <= err_stage_d;
    end
  end

endmodule

// File: tb/tb_reset_release_sequencer.sv
// Testbench for reset_release_sequencer: randomized and directed stimulus
// checked against a stage-count reference model.
module tb_reset_release_sequencer;

  localparam int unsigned N    = 3;
  localparam int unsigned SYNC = 2;
  localparam int unsigned HOLD = 4;
  localparam int unsigned TO   = 10;

  logic         clk = 1'b0;
  logic         clk_en = 1'b1;
  logic         reset_n, soft_reset;
  logic [N-1:0] stage_ready, stage_reset;
  logic         all_ready, busy, timeout_err;
  logic [1:0]   err_stage;

  // Second instance: single stage, timeout disabled.
  logic         reset_n2, soft_reset2;
  logic [0:0]   stage_ready2, stage_reset2;
  logic         all_ready2, busy2, timeout_err2;
  logic [0:0]   err_stage2;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  int m_sync_left, m_hold, m_rel, m_age, m_errst;
  bit m_done, m_err;

  reset_release_sequencer #(
    .NUM_STAGES(N), .SYNC_STAGES(SYNC), .HOLD_CYCLES(HOLD), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset_n(reset_n), .soft_reset(soft_reset), .stage_ready(stage_ready),
    .stage_reset(stage_reset), .all_ready(all_ready), .busy(busy),
    .timeout_err(timeout_err), .err_stage(err_stage)
  );

  reset_release_sequencer #(
    .NUM_STAGES(1), .SYNC_STAGES(3), .HOLD_CYCLES(3), .TIMEOUT_CYCLES(0)
  ) dut2 (
    .clk(clk), .reset_n(reset_n2), .soft_reset(soft_reset2), .stage_ready(stage_ready2),
    .stage_reset(stage_reset2), .all_ready(all_ready2), .busy(busy2),
    .timeout_err(timeout_err2), .err_stage(err_stage2)
  );

  initial begin
    forever begin
      #5;
      if (clk_en) clk = ~clk;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic model_clear();
    m_hold = 0; m_rel = 0; m_age = 0; m_done = 0; m_err = 0; m_errst = 0;
  endtask

  task automatic model_reset();
    m_sync_left = SYNC;
    model_clear();
  endtask

  // One clock edge of the reference model. m_rel counts released stages;
  // m_age counts edges since the most recent release.
  task automatic model_step(input logic rn, input logic sr, input logic [N-1:0] rdy);
    if (!rn) begin
      model_reset();
      return;
    end
    if (m_sync_left > 0) begin
      m_sync_left--;
      model_clear();
      return;
    end
    if (sr) begin
      model_clear();
      return;
    end
    if (m_err) return;
    if (m_done) begin
`ifdef RST_SEQ_READY_MON_EN
      if (rdy != '1) begin
        m_err = 1;
        for (int i = 0; i < N; i++) begin
          if (!rdy[i]) begin
            m_errst = i;
            break;
          end
        end
      end
`endif
      return;
    end
    if (m_rel == 0) begin
      m_hold++;
      if (m_hold == HOLD) begin
        m_rel = 1;
        m_age = 0;
      end
      return;
    end
    m_age++;
    if (m_age >= 2 && rdy[m_rel-1]) begin
      if (m_rel == N) m_done = 1;
      else begin
        m_rel++;
        m_age = 0;
      end
    end else if (TO != 0 && m_age >= TO) begin
      m_err   = 1;
      m_errst = m_rel - 1;
    end
  endtask

  function automatic logic [N-1:0] exp_rst();
    logic [N-1:0] r;
    for (int i = 0; i < N; i++) r[i] = m_err || (i >= m_rel);
    return r;
  endfunction

  task automatic compare_all();
    check("stage_reset", 32'(stage_reset), 32'(exp_rst()));
    check("all_ready", 32'(all_ready), 32'(m_done));
    check("busy", 32'(busy), 32'(!m_done && !m_err));
    check("timeout_err", 32'(timeout_err), 32'(m_err));
    check("err_stage", 32'(err_stage), 32'(m_errst));
  endtask

  task automatic cyc();
    logic         rn, sr;
    logic [N-1:0] rdy;
    @(posedge clk);
    rn = reset_n; sr = soft_reset; rdy = stage_ready;
    model_step(rn, sr, rdy);
    #1;
    compare_all();
  endtask

  // Drop reset_n with the clock stopped, then restart and release.
  task automatic async_rst();
    clk_en = 1'b0;
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    compare_all();
    clk_en = 1'b1;
    cyc();
    cyc();
    reset_n = 1'b1;
  endtask

  initial begin
    bit found;
    int mode, len;

    reset_n = 1'b1; reset_n2 = 1'b1;
    soft_reset = 1'b0; soft_reset2 = 1'b0;
    stage_ready = '0; stage_ready2 = '0;
    #2;
    reset_n = 1'b0; reset_n2 = 1'b0;
    model_reset();
    #1;
    compare_all();
    check("dut2_rst_stage_reset", 32'(stage_reset2), 32'd1);
    check("dut2_rst_busy", 32'(busy2), 32'd1);

    // Single stage, timeout disabled: ready low forever never errors.
    cyc();
    reset_n2 = 1'b1;
    for (int c = 0; c < 300; c++) cyc();
    check("dut2_released", 32'(stage_reset2), 32'd0);
    check("dut2_busy", 32'(busy2), 32'd1);
    check("dut2_no_err", 32'(timeout_err2), 32'd0);
    check("dut2_not_ready", 32'(all_ready2), 32'd0);
    stage_ready2 = 1'b1;
    cyc();
    cyc();
    check("dut2_all_ready", 32'(all_ready2), 32'd1);
    check("dut2_idle", 32'(busy2), 32'd0);
    check("dut2_err_stage", 32'(err_stage2), 32'd0);

    // Full sequence with ready tied high.
    stage_ready = '1;
    reset_n = 1'b1;
    for (int c = 0; c < 16; c++) cyc();
    check("seq_all_ready", 32'(all_ready), 32'd1);

    // Stage 1 never answers -> timeout on stage 1, held until soft_reset.
    async_rst();
    stage_ready = 3'b101;
    for (int c = 0; c < 40; c++) cyc();
    check("to_err", 32'(timeout_err), 32'd1);
    check("to_stage", 32'(err_stage), 32'd1);
    check("to_rst", 32'(stage_reset), 32'b111);
    soft_reset = 1'b1;
    cyc();
    soft_reset = 1'b0;
    check("soft_clear", 32'(timeout_err), 32'd0);

    // Soft reset while waiting on stage 2, then rerun.
    stage_ready = 3'b011;
    for (int c = 0; c < 12; c++) cyc();
    soft_reset = 1'b1;
    cyc();
    soft_reset = 1'b0;
    stage_ready = '1;
    for (int c = 0; c < 16; c++) cyc();

    // Ready rising on exactly the timeout edge wins.
    soft_reset = 1'b1;
    stage_ready = '0;
    cyc();
    soft_reset = 1'b0;
    found = 0;
    for (int c = 0; c < 40 && !found; c++) begin
      cyc();
      if (m_rel == 1 && m_age == TO - 1) found = 1;
    end
    check("to_edge_reached", 32'(found), 32'd1);
    stage_ready = 3'b001;
    cyc();
    check("to_edge_no_err", 32'(timeout_err), 32'd0);
    check("to_edge_rst", 32'(stage_reset), 32'b100);

    // Drop one ready for a single cycle while all stages are up.
    stage_ready = '1;
    for (int c = 0; c < 12; c++) cyc();
    stage_ready = 3'b011;
    cyc();
    stage_ready = '1;
    cyc();
`ifdef RST_SEQ_READY_MON_EN
    check("mon_err", 32'(timeout_err), 32'd1);
    check("mon_stage", 32'(err_stage), 32'd2);
`else
    check("nomon_ready", 32'(all_ready), 32'd1);
`endif

    // Randomized episodes.
    for (int ep = 0; ep < 80; ep++) begin
      mode = $urandom_range(0, 3);
      len  = $urandom_range(20, 80);
      for (int c = 0; c < len; c++) begin
        case (mode)
          0:       stage_ready = '1;
          1:       stage_ready = 3'($urandom);
          2:       stage_ready = 3'($urandom) & 3'($urandom) & 3'($urandom);
          default: stage_ready = ($urandom_range(0, 15) == 0) ? 3'($urandom) : '1;
        endcase
        soft_reset = ($urandom_range(0, 63) == 0) ? 1'b1 : soft_reset && ($urandom_range(0, 1) == 0);
        cyc();
      end
      soft_reset = 1'b0;
      if ($urandom_range(0, 7) == 0) async_rst();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
